// File: rtl/temp_disp_pkg.sv
// Shared constants, FSM state encoding and sample capture helper for the
// temperature display scan controller.
package temp_disp_pkg;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_MINUS = 4'd11;
    localparam logic [3:0] CODE_C     = 4'd12;
    localparam logic [3:0] CODE_F     = 4'd15;

    localparam int MAG_W      = 7;
    localparam int CONV_STEPS = MAG_W;
    localparam int SAT_LIMIT  = 99;
    localparam logic [MAG_W-1:0] SAT_MAG = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV,
        ST_COMMIT
    } state_e;

    typedef struct packed {
        logic             neg;
        logic             sat;
        logic             unit;
        logic [MAG_W-1:0] mag;
    } sample_t;

    // -128 has no positive 8-bit twin; the 8-bit unsigned view of its negation is 128.
    function automatic sample_t sample_capture(input logic [7:0] t, input logic u);
        sample_t    s;
        logic [7:0] a;
        a      = t[7] ? (~t + 8'd1) : t;
        s.neg  = t[7];
        s.unit = u;
        s.sat  = (a > {1'b0, SAT_MAG});
        s.mag  = s.sat ? SAT_MAG : a[MAG_W-1:0];
        return s;
    endfunction

endpackage

// File: rtl/temp_bin2bcd_seq.sv
// Sequential shift-add-3 binary to two-digit BCD engine. A start pulse loads
// the magnitude; done is high during the cycle whose edge performs the last shift.
module temp_bin2bcd_seq
    import temp_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAG_W-1:0] bin_in,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    logic [MAG_W-1:0] sh_q, sh_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [7:0]       adj;

    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        if (start) begin
            sh_d   = bin_in;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[6:0], sh_q[MAG_W-1]};
            sh_d  = {sh_q[MAG_W-2:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(CONV_STEPS - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done = busy_q && (cnt_q == 3'(CONV_STEPS - 1));
    assign tens = bcd_q[7:4];
    assign ones = bcd_q[3:0];

endmodule

// File: rtl/temp_disp_scan_ctrl.sv
// Temperature display controller: sample accept, BCD conversion, atomic frame
// commit and digit scan. TEMP_DISP_LZ_BLANK_EN blanks a zero tens digit.
module temp_disp_scan_ctrl
    import temp_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            temp_in,
    input  logic                  unit_f,
    input  logic                  temp_valid,
    output logic                  temp_ready,
    output logic [3:0]            bcd_code,
    output logic [NUM_DIGITS-1:0] digit_sel_n,
    output logic                  sat_flag
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    generate
        if (NUM_DIGITS != 4 || SCAN_DIV < 2) begin : g_bad_cfg
            $error("temp_disp_scan_ctrl: NUM_DIGITS must be 4 and SCAN_DIV >= 2");
        end
    endgenerate

    // Reset asserts asynchronously but releases two clocks after rst_n rises.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_n_int = rst_sync_q[1];

    state_e                         state_q, state_d;
    sample_t                        sample_q, sample_d;
    logic [NUM_DIGITS-1:0][3:0]     frame_q, frame_d, commit_frame;
    logic                           sat_q, sat_d;
    logic                           conv_start, conv_done;
    logic [3:0]                     conv_tens, conv_ones;
    logic                           neg_show;
    logic [3:0]                     sign_code;

    temp_bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .rst_n  (rst_n_int),
        .start  (conv_start),
        .bin_in (sample_q.mag),
        .done   (conv_done),
        .tens   (conv_tens),
        .ones   (conv_ones)
    );

    always_comb begin
        commit_frame = {NUM_DIGITS{CODE_BLANK}};
        neg_show     = sample_q.neg && (sample_q.mag != '0);
        sign_code    = neg_show ? CODE_MINUS : CODE_BLANK;
        commit_frame[0] = sample_q.unit ? CODE_F : CODE_C;
        commit_frame[1] = conv_ones;
`ifdef TEMP_DISP_LZ_BLANK_EN
        if (conv_tens == 4'd0) begin
            commit_frame[2] = sign_code;
            commit_frame[3] = CODE_BLANK;
        end else begin
            commit_frame[2] = conv_tens;
            commit_frame[3] = sign_code;
        end
`else
        commit_frame[2] = conv_tens;
        commit_frame[3] = sign_code;
`endif
    end

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        frame_d    = frame_q;
        sat_d      = sat_q;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (temp_valid) begin
                    sample_d = sample_capture(temp_in, unit_f);
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                conv_start = 1'b1;
                state_d    = ST_CONV;
            end
            ST_CONV: begin
                if (conv_done) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                frame_d = commit_frame;
                sat_d   = sample_q.sat;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign temp_ready = (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
            frame_q  <= {NUM_DIGITS{CODE_BLANK}};
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            frame_q  <= frame_d;
            sat_q    <= sat_d;
        end
    end

    // Scan path reads the committed frame only, so a digit never shows a half-updated value.
    logic [PW-1:0]         presc_q, presc_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            bcd_code_q, bcd_code_d;
    logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
    logic                  tc;

    always_comb begin
        tc         = (presc_q == PW'(SCAN_DIV - 1));
        presc_d    = tc ? '0 : presc_q + 1'b1;
        idx_d      = tc ? idx_q + 2'd1 : idx_q;
        sel_n_d    = '1;
        sel_n_d[idx_d] = 1'b0;
        bcd_code_d = frame_q[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            presc_q    <= '0;
            idx_q      <= '0;
            bcd_code_q <= CODE_BLANK;
            sel_n_q    <= '1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            bcd_code_q <= bcd_code_d;
            sel_n_q    <= sel_n_d;
        end
    end

    assign bcd_code    = bcd_code_q;
    assign digit_sel_n = sel_n_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_temp_disp_scan_ctrl.sv
// Self-checking bench for temp_disp_scan_ctrl: timed reference model of accept,
// commit and scan, checked every cycle plus directed frame checks.
module tb_temp_disp_scan_ctrl;

    localparam int SD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [7:0] temp_in = '0;
    logic              unit_f = 1'b0;
    logic              temp_valid = 1'b0;
    logic              temp_ready;
    logic [3:0]        bcd_code;
    logic [3:0]        digit_sel_n;
    logic              sat_flag;

    always #5 clk = ~clk;

    temp_disp_scan_ctrl #(.SCAN_DIV(SD), .NUM_DIGITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .temp_in     (temp_in),
        .unit_f      (unit_f),
        .temp_valid  (temp_valid),
        .temp_ready  (temp_ready),
        .bcd_code    (bcd_code),
        .digit_sel_n (digit_sel_n),
        .sat_flag    (sat_flag)
    );

    int         n_asrt = 0;
    int         n_fail = 0;
    int         n = 0;
    int         commit_n = 0;
    bit         pending = 1'b0;
    bit         msat = 1'b0;
    bit         psat = 1'b0;
    logic [3:0] mframe [4];
    logic [3:0] pframe [4];
    int         dut_accepts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // Display content straight from the rules: magnitude, clamp, decimal digits.
    function automatic void calc(input int t, input bit u, output logic [3:0] f [4], output bit s);
        int a, m, tens, ones;
        bit neg;
        a    = (t < 0) ? -t : t;
        s    = (a > 99);
        m    = s ? 99 : a;
        tens = m / 10;
        ones = m % 10;
        neg  = (t < 0) && (m != 0);
        f[0] = u ? 4'd15 : 4'd12;
        f[1] = 4'(ones);
`ifdef TEMP_DISP_LZ_BLANK_EN
        if (tens == 0) begin
            f[2] = neg ? 4'd11 : 4'd10;
            f[3] = 4'd10;
        end else begin
            f[2] = 4'(tens);
            f[3] = neg ? 4'd11 : 4'd10;
        end
`else
        f[2] = 4'(tens);
        f[3] = neg ? 4'd11 : 4'd10;
`endif
    endfunction

    task automatic tick();
        logic [3:0] exp_bcd;
        int idx;
        if (temp_ready === 1'b1 && temp_valid) dut_accepts++;
        @(posedge clk);
        n++;
        idx     = (n / SD) % 4;
        exp_bcd = mframe[idx];
        if (pending && n == commit_n) begin
            mframe  = pframe;
            msat    = psat;
            pending = 1'b0;
        end else if (!pending && temp_valid) begin
            calc(int'(temp_in), unit_f, pframe, psat);
            pending  = 1'b1;
            commit_n = n + 9;
        end
        #1;
        chk("temp_ready", 32'(temp_ready), 32'(!pending));
        chk("digit_sel_n", 32'(digit_sel_n), 32'hF ^ (32'h1 << idx));
        chk("bcd_code", 32'(bcd_code), 32'(exp_bcd));
        chk("sat_flag", 32'(sat_flag), 32'(msat));
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset();
        temp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_sel_n", 32'(digit_sel_n), 32'hF);
        chk("rst_bcd", 32'(bcd_code), 32'd10);
        chk("rst_ready", 32'(temp_ready), 32'd1);
        chk("rst_sat", 32'(sat_flag), 32'd0);
        for (int i = 0; i < 4; i++) mframe[i] = 4'd10;
        pending = 1'b0;
        msat    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rel_sel_n", 32'(digit_sel_n), 32'hF);
        chk("rst_rel_bcd", 32'(bcd_code), 32'd10);
        n = 0;
    endtask

    task automatic send(input int t, input bit u);
        temp_in    = 8'(t);
        unit_f     = u;
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
        ticks(9);
    endtask

    // One full rotation, each slot compared against a fixed expected frame.
    task automatic check_frame(input string tag, input int d3, input int d2, input int d1,
                               input int d0, input bit s);
        int want [4];
        want[0] = d0; want[1] = d1; want[2] = d2; want[3] = d3;
        temp_valid = 1'b0;
        for (int i = 0; i < 4 * SD; i++) begin
            tick();
            chk(tag, 32'(bcd_code), 32'(want[(n / SD) % 4]));
        end
        chk({tag, "_sat"}, 32'(sat_flag), 32'(s));
    endtask

    initial begin
        int acc0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_frame("blank_scan", 10, 10, 10, 10, 1'b0);

        send(37, 1'b0);
        check_frame("frame_37C", 10, 3, 7, 12, 1'b0);

        send(-5, 1'b1);
`ifdef TEMP_DISP_LZ_BLANK_EN
        check_frame("frame_m5F", 10, 11, 5, 15, 1'b0);
`else
        check_frame("frame_m5F", 11, 0, 5, 15, 1'b0);
`endif

        send(127, 1'b0);
        check_frame("frame_127", 10, 9, 9, 12, 1'b1);
        send(-128, 1'b1);
        check_frame("frame_m128", 11, 9, 9, 15, 1'b1);

        send(0, 1'b0);
`ifdef TEMP_DISP_LZ_BLANK_EN
        check_frame("frame_0", 10, 10, 0, 12, 1'b0);
`else
        check_frame("frame_0", 10, 0, 0, 12, 1'b0);
`endif

        // Valid held high with fresh data every cycle: one accept per 10 cycles.
        acc0 = dut_accepts;
        temp_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            temp_in = 8'($urandom);
            unit_f  = 1'($urandom);
            tick();
        end
        temp_valid = 1'b0;
        chk("accept_count", 32'(dut_accepts - acc0), 32'd6);
        ticks(12);

        for (int i = 0; i < 200; i++) begin
            temp_valid = ($urandom_range(0, 3) == 0);
            temp_in    = 8'($urandom);
            unit_f     = 1'($urandom);
            tick();
        end
        temp_valid = 1'b0;
        ticks(12);

        // Reset at E5 of a conversion aborts it and blanks the display.
        temp_in    = -8'sd42;
        unit_f     = 1'b0;
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
        ticks(5);
        do_reset();
        chk("post_rst_ready", 32'(temp_ready), 32'd1);
        send(64, 1'b1);
        check_frame("frame_64F", 10, 6, 4, 15, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
